// File: rtl/q7_pkg.sv
// Shared Q1.7 constants and state encoding for the multiplier and downstream Q1.7 stages.
package q7_pkg;

  localparam logic signed [7:0] Q7_MAX = 8'sh7f;
  localparam logic signed [7:0] Q7_MIN = 8'sh80;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } q7_state_e;

endpackage

// File: rtl/q7_sat.sv
// Clamps a signed IN_W value into the Q1.7 range and flags when clamping occurred.
module q7_sat
  import q7_pkg::*;
#(
  parameter int unsigned IN_W = 16
) (
  input  logic signed [IN_W-1:0] in_val,
  output logic        [7:0]      out_val,
  output logic                   clamped
);

  localparam logic signed [IN_W-1:0] MaxV = IN_W'(Q7_MAX);
  localparam logic signed [IN_W-1:0] MinV = IN_W'(Q7_MIN);

  always_comb begin
    out_val = in_val[7:0];
    clamped = 1'b0;
    if (in_val > MaxV) begin
      out_val = Q7_MAX;
      clamped = 1'b1;
    end else if (in_val < MinV) begin
      out_val = Q7_MIN;
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/q7_dot_accumulator.sv
// Streaming Q1.7 dot-product: accumulates product beats per vector, emits one saturated result.
module q7_dot_accumulator
  import q7_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  q7_state_e               state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;

  logic signed [ACC_W:0]   sum;
  logic                    acc_ovf;
  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        cnt_inc;
  logic [7:0]              sat_val;
  logic                    sat_clamped;
  logic                    beat_acc;

  // One guard bit is enough: a single 8-bit addend can overflow ACC_W by at most one bit.
  assign sum      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){in_data[7]}}, in_data};
  assign acc_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
  assign acc_next = acc_ovf ? (sum[ACC_W] ? AccMin : AccMax) : sum[ACC_W-1:0];
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  q7_sat #(
    .IN_W(ACC_W)
  ) u_sat (
    .in_val (acc_next),
    .out_val(sat_val),
    .clamped(sat_clamped)
  );

  assign in_ready  = (state_q != StHold);
  assign out_valid = (state_q == StHold);
  assign beat_acc  = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (beat_acc) begin
          acc_d    = acc_next;
          cnt_d    = cnt_inc;
          sticky_d = sticky_q | acc_ovf;
          if (in_last) begin
            state_d     = StHold;
            out_data_d  = sat_val;
            out_sat_d   = sticky_q | acc_ovf | sat_clamped;
            out_count_d = cnt_inc;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d  = StIdle;
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_data_q  <= 8'h00;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_q7_dot_accumulator.sv
// Directed bench: vector table for ACC_W=16 and ACC_W=9 instances, plus multi-cycle sequences.
module tb_q7_dot_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_sat;
  logic [7:0] out_data, out_count;
  logic       in_ready9, out_valid9, out_sat9;
  logic [7:0] out_data9, out_count9;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  q7_dot_accumulator #(.ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_count(out_count)
  );

  q7_dot_accumulator #(.ACC_W(9), .CNT_W(8)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready9), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid9), .out_ready(out_ready), .out_data(out_data9),
    .out_sat(out_sat9), .out_count(out_count9)
  );

  typedef struct {
    int              n;
    logic [4:0][7:0] d;
    logic [7:0]      exp_data;
    logic            exp_sat;
    logic [7:0]      exp_cnt;
    logic [7:0]      exp9_data;
    logic            exp9_sat;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3, b4,
                              input logic [7:0] ed, input logic es, input logic [7:0] ec,
                              input logic [7:0] e9d, input logic e9s);
    vec_t v;
    v.n = n;
    v.d = {b4, b3, b2, b1, b0};
    v.exp_data = ed;
    v.exp_sat = es;
    v.exp_cnt = ec;
    v.exp9_data = e9d;
    v.exp9_sat = e9s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Holds the beat until accepted; returns #1 after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    // Sums: 0x40+0x20; 3x0x60=288; 2x0x80=-256; single 0xF0; 3x0x7F-2x0x7F (9-bit clamps at 255
    // on beat 3, so 255-254=1 with sticky); 0xC0+0x20+0xF0=-48; 0x10+0x10.
    vecs[0] = mk(2, 8'h40, 8'h20, 8'h00, 8'h00, 8'h00, 8'h60, 1'b0, 8'd2, 8'h60, 1'b0);
    vecs[1] = mk(3, 8'h60, 8'h60, 8'h60, 8'h00, 8'h00, 8'h7F, 1'b1, 8'd3, 8'h7F, 1'b1);
    vecs[2] = mk(2, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80, 1'b1, 8'd2, 8'h80, 1'b1);
    vecs[3] = mk(1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 1'b0, 8'd1, 8'hF0, 1'b0);
    vecs[4] = mk(5, 8'h7F, 8'h7F, 8'h7F, 8'h81, 8'h81, 8'h7F, 1'b0, 8'd5, 8'h01, 1'b1);
    vecs[5] = mk(3, 8'hC0, 8'h20, 8'hF0, 8'h00, 8'h00, 8'hD0, 1'b0, 8'd3, 8'hD0, 1'b0);
    vecs[6] = mk(2, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 1'b0, 8'd2, 8'h20, 1'b0);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table: out_ready high, so the result is taken the cycle after it appears
    out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < vecs[v].n; b++) send_beat(vecs[v].d[b], (b == vecs[v].n - 1));
      chk($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_in_ready_hold", v), 32'(in_ready), 32'd0);
      chk($sformatf("v%0d_out_data", v), 32'(out_data), 32'(vecs[v].exp_data));
      chk($sformatf("v%0d_out_sat", v), 32'(out_sat), 32'(vecs[v].exp_sat));
      chk($sformatf("v%0d_out_count", v), 32'(out_count), 32'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_acc9_data", v), 32'(out_data9), 32'(vecs[v].exp9_data));
      chk($sformatf("v%0d_acc9_sat", v), 32'(out_sat9), 32'(vecs[v].exp9_sat));
      @(posedge clk); #1;
      chk($sformatf("v%0d_after_take_valid", v), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_after_take_ready", v), 32'(in_ready), 32'd1);
    end

    // Back-to-back: single-beat vector, next beat driven right after the take
    send_beat(8'hF0, 1'b1);
    @(posedge clk); #1;
    send_beat(8'h05, 1'b1);
    chk("b2b_out_valid", 32'(out_valid), 32'd1);
    chk("b2b_out_data", 32'(out_data), 32'h05);
    chk("b2b_out_count", 32'(out_count), 32'd1);
    @(posedge clk); #1;

    // Backpressure: hold result 5 cycles with a pending beat on the input
    out_ready = 1'b0;
    send_beat(8'h40, 1'b0);
    send_beat(8'h20, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_out_data", c), 32'(out_data), 32'h60);
      chk($sformatf("bp%0d_out_sat", c), 32'(out_sat), 32'd0);
      chk($sformatf("bp%0d_out_count", c), 32'(out_count), 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_take_valid", 32'(out_valid), 32'd0);
    chk("bp_take_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_held_beat_valid", 32'(out_valid), 32'd1);
    chk("bp_held_beat_data", 32'(out_data), 32'h11);
    chk("bp_held_beat_count", 32'(out_count), 32'd1);
    @(posedge clk); #1;

    // Beat counter saturates at 255
    for (int b = 0; b < 260; b++) send_beat(8'h00, (b == 259));
    chk("cnt_sat_count", 32'(out_count), 32'd255);
    chk("cnt_sat_data", 32'(out_data), 32'h00);
    chk("cnt_sat_sat", 32'(out_sat), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-vector; previous result (0x00) replaced first by a nonzero one
    send_beat(8'h33, 1'b1);
    @(posedge clk); #1;
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'h00);
    chk("arst_out_sat", 32'(out_sat), 32'd0);
    chk("arst_out_count", 32'(out_count), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(8'h10, 1'b0);
    send_beat(8'h10, 1'b1);
    chk("arst_new_valid", 32'(out_valid), 32'd1);
    chk("arst_new_data", 32'(out_data), 32'h20);
    chk("arst_new_count", 32'(out_count), 32'd2);
    chk("arst_new_sat", 32'(out_sat), 32'd0);
    chk("arst_new_data9", 32'(out_data9), 32'h20);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
